ddr_sample_packer: RTL

- Downstream neighbour of the dual-edge capture stage.
- Consumes one rising-edge sample and one falling-edge sample per clk cycle and packs consecutive sample pairs into OUT_W-bit words.
- Delivers the words over a valid/ready interface through a 2-entry output FIFO.
- The input side never stalls, because the capture stage is free-running. Words that cannot be stored are dropped and flagged.

---
 rtl/ddr_pack_pkg.sv | 12 +
 rtl/ddr_pack_fifo2.sv | 57 +++++
 rtl/ddr_sample_packer.sv | 98 +++++++++
 3 files changed

// File: rtl/ddr_pack_pkg.sv
// Shared constants and helpers for the DDR sample packer.
package ddr_pack_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned DROP_CNT_W = 16;

    function automatic int unsigned calc_beats(input int unsigned sample_w,
                                               input int unsigned out_w);
        return out_w / (2 * sample_w);
    endfunction

endpackage

// File: rtl/ddr_pack_fifo2.sv
// Two-entry FIFO; head is a register so data stays stable while the head waits.
module ddr_pack_fifo2
    import ddr_pack_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] head_q, tail_q;
    logic [1:0]       count_q;
    logic             rd, wr;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'(FIFO_DEPTH));
    assign head  = head_q;
    assign rd    = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign wr    = push && (!full || rd);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({wr, rd})
                2'b10: begin
                    if (empty) head_q <= push_data;
                    else       tail_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ddr_sample_packer.sv
// Packs rise/fall sample pairs LSB-first into OUT_W-bit words behind a 2-entry FIFO.
// Optional drop counter enabled by defining DDR_PACKER_DROP_CNT_EN.
module ddr_sample_packer
    import ddr_pack_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 1,
    parameter int unsigned OUT_W    = 8
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic                  in_valid,
    input  logic [SAMPLE_W-1:0]   d_rise,
    input  logic [SAMPLE_W-1:0]   d_fall,
    input  logic                  flush,
    input  logic                  clr_overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_partial,
    output logic                  overflow
`ifdef DDR_PACKER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int unsigned BEATS = calc_beats(SAMPLE_W, OUT_W);
    localparam int unsigned CNT_W = $clog2(BEATS + 1);

    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic [OUT_W-1:0] shreg_q, packed_word;
    logic             complete, do_push, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [OUT_W:0]   fifo_head;

    always_comb begin
        packed_word = shreg_q;
        if (in_valid) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    packed_word[2*k*SAMPLE_W +: SAMPLE_W]     = d_rise;
                    packed_word[(2*k+1)*SAMPLE_W +: SAMPLE_W] = d_fall;
                end
            end
        end
    end

    assign cnt_inc  = cnt_q + CNT_W'(in_valid);
    assign complete = in_valid && (cnt_q == CNT_W'(BEATS - 1));
    // Flush only emits when the word holds at least one beat, including this cycle's.
    assign do_push  = complete || (flush && (cnt_inc != '0));
    assign pop      = out_valid && out_ready;
    assign drop     = do_push && fifo_full && !pop;

    ddr_pack_fifo2 #(
        .WIDTH(OUT_W + 1)
    ) u_fifo (
        .clk      (clk),
        .areset_n (areset_n),
        .push     (do_push),
        .push_data({!complete, packed_word}),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_head[OUT_W-1:0];
    assign out_partial = fifo_head[OUT_W];

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q    <= '0;
            shreg_q  <= '0;
            overflow <= 1'b0;
        end else begin
            // Clearing the shift register keeps unfilled bits of a flushed word zero.
            cnt_q   <= do_push ? '0 : cnt_inc;
            shreg_q <= do_push ? '0 : packed_word;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

`ifdef DDR_PACKER_DROP_CNT_EN
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            drop_cnt <= '0;
        end else if (clr_overflow) begin
            drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
`endif

endmodule
